// File: rtl/sub_chain_16bit_unsigned.sv
// sub_chain_16bit_unsigned: streaming multi-limb unsigned subtractor, one 16-bit limb per transfer,
// borrow chained LSB-first, one-deep registered output with ready/valid handshakes.
module sub_chain_16bit_unsigned #(
    parameter int MAX_LIMBS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_diff,
    output logic        out_borrow,
    output logic        out_last,
    output logic [3:0]  out_idx,
    output logic        err_len
);
    typedef enum logic {IDLE, MID} state_t;
    state_t      state;
    logic [3:0]  limb_cnt;
    logic        borrow_q;
    logic        take;
    logic        at_max;
    logic        done;
    logic        borrow_in;
    logic [16:0] t;
    assign in_ready  = !out_valid || out_ready;
    assign take      = in_valid && in_ready;
    assign borrow_in = (state == MID) && borrow_q;
    assign t         = {1'b0, in_a} - {1'b0, in_b} - {16'd0, borrow_in};
    assign at_max    = limb_cnt == 4'(MAX_LIMBS - 1);
    // A limb at the length ceiling closes the operation even without in_last.
    assign done      = in_last || at_max;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            limb_cnt   <= 4'd0;
            borrow_q   <= 1'b0;
            out_valid  <= 1'b0;
            out_diff   <= 16'd0;
            out_borrow <= 1'b0;
            out_last   <= 1'b0;
            out_idx    <= 4'd0;
            err_len    <= 1'b0;
        end else if (take) begin
            out_valid  <= 1'b1;
            out_diff   <= t[15:0];
            out_borrow <= t[16];
            out_last   <= done;
            out_idx    <= limb_cnt;
            err_len    <= err_len || (at_max && !in_last);
            state      <= done ? IDLE : MID;
            borrow_q   <= done ? 1'b0 : t[16];
            limb_cnt   <= done ? 4'd0 : limb_cnt + 4'd1;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end
endmodule
